// File: rtl/raycast_pkg.sv
// Shared ray-cast column constants, record type and encoder states.
// The decoder side uses the same constants.
package raycast_pkg;

  localparam int SCREEN_COLS  = 640;
  localparam int SCREEN_ROWS  = 480;
  localparam int SF_NUMERATOR = 32768;

  localparam logic [15:0] HALF_ROWS = 16'(SCREEN_ROWS / 2);
  localparam logic [9:0]  LAST_COL  = 10'(SCREEN_COLS - 1);

  typedef struct packed {
    logic [15:0] height;
    logic        wall_dir;
    logic [2:0]  tex_type;
    logic [5:0]  tex_col;
  } column_rec_t;

  typedef enum logic [2:0] {
    IDLE,
    DIV,
    W0,
    W1,
    W2,
    W3,
    PAD
  } enc_state_t;

  function automatic logic [15:0] wall_top(input logic [15:0] h);
    return HALF_ROWS - (h >> 1);
  endfunction

  function automatic logic [15:0] word0(input column_rec_t r);
    return {6'b0, r.wall_dir, r.tex_type, r.tex_col};
  endfunction

endpackage

// File: rtl/sf_divider.sv
// Restoring divider, NUMERATOR / divisor, one quotient bit per cycle.
// Fixed 16-cycle latency; a zero divisor saturates to all ones.
module sf_divider #(
  parameter int unsigned NUMERATOR = 32768
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [15:0] divisor,
  output logic        busy,
  output logic        done,
  output logic [15:0] quotient
);

  localparam logic [15:0] NUM = 16'(NUMERATOR);

  logic [15:0] dividend;
  logic [15:0] quot;
  logic [15:0] dvs;
  logic [15:0] rem;
  logic [3:0]  cnt;
  logic [16:0] trial;
  logic        fits;

  // Partial remainder is 17 bits wide before the compare-subtract.
  always_comb begin
    trial = {rem, dividend[15]};
    fits  = trial >= {1'b0, dvs};
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      dividend <= '0;
      quot     <= '0;
      dvs      <= '0;
      rem      <= '0;
      cnt      <= '0;
      busy     <= 1'b0;
    end else if (start) begin
      dividend <= NUM;
      quot     <= '0;
      dvs      <= divisor;
      rem      <= '0;
      cnt      <= '0;
      busy     <= 1'b1;
    end else if (busy) begin
      rem      <= fits ? 16'(trial - {1'b0, dvs})
                       : trial[15:0];
      quot     <= {quot[14:0], fits};
      dividend <= dividend << 1;
      cnt      <= cnt + 4'd1;
      if (cnt == 4'd15) busy <= 1'b0;
    end
  end

  assign done     = busy && (cnt == 4'd15);
  assign quotient = (dvs == 16'd0) ? 16'hFFFF : quot;

endmodule

// File: rtl/column_encoder.sv
// Column record to four-word decoder write sequence, with frame
// length enforcement (blank-column padding on short frames).
module column_encoder
  import raycast_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [15:0] in_height,
  input  logic        in_wall_dir,
  input  logic [2:0]  in_tex_type,
  input  logic [5:0]  in_tex_col,
  input  logic        in_last,
  output logic        av_chipselect,
  output logic        av_write,
  output logic [15:0] av_writedata,
  output logic [9:0]  col_count,
  output logic        frame_done,
  output logic        frame_error
);

  enc_state_t  state;
  column_rec_t rec;
  column_rec_t in_rec;
  logic        last_q;
  logic        padding;
  logic        accept;
  logic        div_busy;
  logic        div_done;
  logic [15:0] div_q;
  logic [15:0] sf;

  assign in_rec = '{
    height:   in_height,
    wall_dir: in_wall_dir,
    tex_type: in_tex_type,
    tex_col:  in_tex_col
  };

  assign accept = (state == IDLE) && in_valid && in_ready;
  assign sf     = padding ? 16'hFFFF : div_q;

  sf_divider #(
    .NUMERATOR(SF_NUMERATOR)
  ) u_div (
    .clk      (clk),
    .reset    (reset),
    .start    (accept),
    .divisor  (in_height),
    .busy     (div_busy),
    .done     (div_done),
    .quotient (div_q)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state         <= IDLE;
      rec           <= '0;
      last_q        <= 1'b0;
      padding       <= 1'b0;
      in_ready      <= 1'b0;
      av_write      <= 1'b0;
      av_chipselect <= 1'b0;
      av_writedata  <= '0;
      col_count     <= '0;
      frame_done    <= 1'b0;
      frame_error   <= 1'b0;
    end else begin
      frame_done <= 1'b0;
      unique case (state)
        IDLE: begin
          in_ready <= 1'b1;
          if (accept) begin
            rec      <= in_rec;
            last_q   <= in_last;
            in_ready <= 1'b0;
            state    <= DIV;
          end
        end
        DIV: begin
          if (div_done || !div_busy) begin
            av_write      <= 1'b1;
            av_chipselect <= 1'b1;
            av_writedata  <= word0(rec);
            state         <= W0;
          end
        end
        // PAD is the first word of a blank column
        W0, PAD: begin
          av_writedata <= rec.height;
          state        <= W1;
        end
        W1: begin
          av_writedata <= wall_top(rec.height);
          state        <= W2;
        end
        W2: begin
          av_writedata <= sf;
          state        <= W3;
        end
        W3: begin
          av_write      <= 1'b0;
          av_chipselect <= 1'b0;
          av_writedata  <= '0;
          if (col_count == LAST_COL) begin
            col_count  <= '0;
            frame_done <= 1'b1;
            if (!last_q) frame_error <= 1'b1;
            padding    <= 1'b0;
            in_ready   <= 1'b1;
            state      <= IDLE;
          end else begin
            col_count <= col_count + 10'd1;
            if (padding || last_q) begin
              if (!padding) frame_error <= 1'b1;
              padding       <= 1'b1;
              rec           <= '0;
              av_write      <= 1'b1;
              av_chipselect <= 1'b1;
              state         <= PAD;
            end else begin
              in_ready <= 1'b1;
              state    <= IDLE;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: doc/column_encoder.md
# column_encoder

Producer-side counterpart of the column decoder. It accepts one ray-cast result per screen column over a valid/ready handshake and derives each column's wall top and texture scaling factor, the latter with a sequential divider. It then emits the four-word 16-bit write sequence that the decoder's Avalon-MM slave expects. It sits between the ray-casting engine and the decoder's chipselect/write/writedata port and guarantees exactly SCREEN_COLS columns, in order, per frame.

## Interface
- SCREEN_COLS, 640: columns per frame; the decoder wraps its column index after SCREEN_COLS-1.
- SCREEN_ROWS, 480: visible rows; wall top is derived from this.
- SF_NUMERATOR, 32768: scaling-factor numerator (64 texels << 9).
- clk  in  1  system clock (50 MHz domain shared with the decoder).
- reset  in  1  reset, asynchronous, active-high.
- in_valid  in  1  column record valid.
- in_ready  out  1  block can accept a record.
- in_height  in  16  unsigned wall height in pixels.
- in_wall_dir  in  1  1 = full-brightness face, 0 = faded face.
- in_tex_type  in  3  texture index 0..7.
- in_tex_col  in  6  texture column 0..63.
- in_last  in  1  record is the last column of the frame.
- av_chipselect  out  1  write strobe qualifier; equals av_write.
- av_write  out  1  one decoder word per high cycle.
- av_writedata  out  16  decoder word.
- col_count  out  10  columns fully emitted in the current frame.
- frame_done  out  1  single-cycle pulse after the last column of a frame.
- frame_error  out  1  sticky; frame length mismatch seen.

## Operation
- Word order per column:
  - w0 = {6'b0, wall_dir, tex_type, tex_col}
  - w1 = height
  - w2 = top = SCREEN_ROWS/2 − (height >> 1), signed 16-bit two's complement
  - w3 = sf
- sf = floor(SF_NUMERATOR / height), unsigned 16-bit.
  - height 0 → sf = 16'hFFFF.
  - height 1 → 32768 (fits).
- FSM states are IDLE, DIV, W0, W1, W2, W3, PAD.
  - IDLE: in_ready=1. On in_valid&&in_ready, latch the record and in_last, start the divider, go to DIV.
  - DIV: exactly 16 cycles, also for height 0 (fixed latency). Then go to W0.
  - W0..W3: one cycle each, av_write=av_chipselect=1, av_writedata = the word for that state.
  - After W3, col_count increments and the next state is chosen as follows:
    - Column SCREEN_COLS-1 just sent: col_count←0, pulse frame_done. If latched in_last=0, set frame_error (long frame; the next record starts a new frame). Go to IDLE.
    - Latched in_last=1 and fewer than SCREEN_COLS columns sent: set frame_error, go to PAD.
    - Otherwise go to IDLE.
- PAD: emits a blank column (wall_dir 0, tex 0, height 0, top SCREEN_ROWS/2, sf FFFF) through W0..W3 with no DIV. Repeats until col_count wraps, then frame_done pulses and the FSM returns to IDLE.
  - in_ready=0 throughout padding.
- av_write is low in every state except W0..W3; no other write is ever issued. This keeps the decoder's four-stage word counter aligned.
- frame_error clears only on reset.

## Timing
- All outputs are registered.
- Reset values: in_ready 0 while reset is asserted and 1 in the first cycle after deassertion; av_write 0, av_chipselect 0, av_writedata 0, col_count 0, frame_done 0, frame_error 0. FSM resets to IDLE.
- Handshake accepted on edge t: in_ready low from t+1; av_write high on cycles t+17..t+20; in_ready high again on t+21. Throughput is 21 cycles per column, 13,440 cycles per frame, which is well inside one 840,000-cycle frame.
- Padding costs 4 cycles per column with back-to-back writes; it returns to IDLE after the final W3.
- frame_done is high for the single cycle after the frame's final W3 write.
- Reset mid-column: av_write drops asynchronously and the partial column is abandoned. The decoder shares the reset, so both ends restart at word 0, column 0.
- Divider: restoring, 1 quotient bit per cycle, 17-bit partial remainder, MSB first.

## Structure
- Package raycast_pkg holds:
  - SCREEN_COLS, SCREEN_ROWS, SF_NUMERATOR
  - typedef struct packed column_rec_t {height, wall_dir, tex_type, tex_col}
  - typedef enum enc_state_t for the FSM states
- The decoder imports the same constants.
- Sub-module sf_divider: start/busy/done, 16-bit divisor, parameterized numerator, fixed 16-cycle latency, zero-divisor saturation.
- FSM, word mux and frame counter stay in column_encoder.

## Test plan
- Basic encode: height 64, dir 1, type 6, col 5 → writes 0x0385, 0x0040, 0x00D0, 0x0200 on t+17..t+20.
- Tall walls:
  - height 600 → w2 0xFFC4, w3 0x0036.
  - height 480 → w2 0x0000, w3 0x0044.
- Zero height: height 0 → w2 0x00F0, w3 0xFFFF, still 16 DIV cycles.
- Full frame: 640 records with in_last on the 640th → exactly 2560 writes, one frame_done, frame_error 0, col_count back to 0.
- Short frame: in_last on the 10th record → 630 pad columns (2520 writes), in_ready low throughout, one frame_done, frame_error 1.
- Reset: assert reset during W1 → av_write 0 immediately. After release, the next record produces a clean four-word sequence and col_count = 1.
